// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared constants, width derivation and output rounding helper for the CIC decimator
package cic_pkg;

    localparam int CIC_WIN   = 16;
    localparam int CIC_WOUT  = 16;
    localparam int CIC_N     = 3;
    localparam int CIC_LOG2R = 3;

    function automatic int cic_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int cic_wacc(input int win, input int n, input int log2r);
        return win + n * log2r;
    endfunction

    localparam int CIC_WACC = cic_wacc(CIC_WIN, CIC_N, CIC_LOG2R);

    typedef logic signed [CIC_WACC-1:0] acc_t;

    // Round half up after dropping 'drop' LSBs, clamped to a signed 'wout'-bit range.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] v,
                                                     input int drop, input int wout);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s = v;
        if (drop > 0) s = s + (64'sd1 <<< (drop - 1));
        s  = s >>> drop;
        hi = (64'sd1 <<< (wout - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        return s;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// rtl/cic_comb_stage.sv - one registered comb section y = x - x_prev, advancing on vin
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int W = CIC_WACC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vin,
    input  logic [W-1:0] x,
    output logic         vout,
    output logic [W-1:0] y
);

    logic [W-1:0] x_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_prev <= '0;
            y      <= '0;
            vout   <= 1'b0;
        end else begin
            vout <= vin;
            if (vin) begin
                y      <= x - x_prev;
                x_prev <= x;
            end
        end
    end

endmodule

// File: rtl/cic_decimator.sv
// rtl/cic_decimator.sv - N-stage CIC decimator by 2^LOG2R; CIC_ROUND_EN selects rounded/saturated output
module cic_decimator
    import cic_pkg::*;
#(
    parameter int WIN   = CIC_WIN,
    parameter int WOUT  = CIC_WOUT,
    parameter int N     = CIC_N,
    parameter int LOG2R = CIC_LOG2R
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WIN-1:0]  din,
    input  logic            val_in,
    output logic [WOUT-1:0] dout,
    output logic            val_out
);

    localparam int WACC  = cic_wacc(WIN, N, LOG2R);
    localparam int QDROP = WACC - WOUT;
    localparam int R     = 1 << LOG2R;
    localparam int CW    = cic_clog2(R);

    logic [CW-1:0]   cnt;
    logic            dec;
    logic [WACC-1:0] integ     [N];
    logic [WACC-1:0] integ_nxt [N];

    // Each stage accumulates the freshly updated value of the stage before it.
    always_comb begin
        integ_nxt[0] = integ[0] + WACC'(signed'(din));
        for (int k = 1; k < N; k++) begin
            integ_nxt[k] = integ[k] + integ_nxt[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) integ[k] <= '0;
            cnt <= '0;
            dec <= 1'b0;
        end else begin
            dec <= val_in && (cnt == CW'(R - 1));
            if (val_in) begin
                cnt <= cnt + 1'b1;
                for (int k = 0; k < N; k++) integ[k] <= integ_nxt[k];
            end
        end
    end

    logic            v0;
    logic [WACC-1:0] x0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0 <= 1'b0;
            x0 <= '0;
        end else begin
            v0 <= dec;
            if (dec) x0 <= integ[N-1];
        end
    end

    logic [N-1:0]           cv;
    logic [N-1:0][WACC-1:0] cy;

    for (genvar k = 0; k < N; k++) begin : g_comb
        if (k == 0) begin : g_first
            cic_comb_stage #(.W(WACC)) u_comb (
                .clk (clk),
                .rst (rst),
                .vin (v0),
                .x   (x0),
                .vout(cv[k]),
                .y   (cy[k])
            );
        end else begin : g_next
            cic_comb_stage #(.W(WACC)) u_comb (
                .clk (clk),
                .rst (rst),
                .vin (cv[k-1]),
                .x   (cy[k-1]),
                .vout(cv[k]),
                .y   (cy[k])
            );
        end
    end

    logic [WACC-1:0] c_out;
    logic [WOUT-1:0] q;

    assign c_out = cy[N-1];

`ifdef CIC_ROUND_EN
    logic signed [63:0] q_full;
    logic               unused_q;

    assign q_full   = round_sat(64'(signed'(c_out)), QDROP, WOUT);
    assign unused_q = ^q_full[63:WOUT];
    assign q        = q_full[WOUT-1:0];
`else
    logic unused_lsb;

    assign unused_lsb = ^c_out[QDROP-1:0];
    assign q          = c_out[WACC-1 -: WOUT];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout    <= '0;
            val_out <= 1'b0;
        end else begin
            val_out <= cv[N-1];
            if (cv[N-1]) dout <= q;
        end
    end

endmodule
